// File: rtl/output_vc_credit_scheduler.sv
// Per-output-port flit scheduler: round-robin arbitration over input VCs
// gated by downstream credits, with per-VC packet framing checks.
module output_vc_credit_scheduler #(
  parameter int V          = 4,
  parameter int V_BW       = 2,
  parameter int CREDIT_NUM = 4,
  parameter int CREDIT_W   = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [V-1:0]    req_i,
  input  logic [V-1:0]    head_i,
  input  logic [V-1:0]    tail_i,
  input  logic            credit_valid_i,
  input  logic [V_BW-1:0] credit_vc_i,
  output logic            grant_valid_o,
  output logic [V-1:0]    grant_o,
  output logic [V_BW-1:0] grant_vc_o,
  output logic [V-1:0]    vc_busy_o,
  output logic [V-1:0]    credit_avail_o,
  output logic            err_o
);

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(CREDIT_NUM);
  localparam logic [V_BW-1:0]     PTR_RESET  = V_BW'(V - 1);

  logic [CREDIT_W-1:0] credit_cnt_q [V];
  logic [CREDIT_W-1:0] credit_cnt_d [V];
  logic [V_BW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [V-1:0]        in_pkt_q, in_pkt_d;
  logic                err_q, err_d;

  logic [V-1:0]        credit_nz;
  logic [V-1:0]        elig;
  logic [V-1:0]        credit_ret;
  logic [V-1:0]        credit_up;
  logic [V-1:0]        credit_dn;
  logic [V-1:0]        credit_ovf;
  logic [V-1:0]        pkt_err;
  logic [V-1:0]        grant_oh;
  logic [V_BW-1:0]     grant_vc;
  logic [V_BW-1:0]     arb_idx;
  logic                arb_found;

  // Per-VC credit accounting and packet framing.
  for (genvar gi = 0; gi < V; gi++) begin : g_vc
    assign credit_nz[gi]  = (credit_cnt_q[gi] != '0);
    assign elig[gi]       = req_i[gi] & credit_nz[gi];
    assign credit_ret[gi] = credit_valid_i && (credit_vc_i == V_BW'(gi));

    // A grant and a return on the same VC cancel out.
    assign credit_up[gi]  = credit_ret[gi] & ~grant_oh[gi];
    assign credit_dn[gi]  = grant_oh[gi] & ~credit_ret[gi];
    assign credit_ovf[gi] = credit_up[gi] & (credit_cnt_q[gi] == CREDIT_MAX);

    assign credit_cnt_d[gi] =
        (credit_up[gi] && !credit_ovf[gi]) ? credit_cnt_q[gi] + CREDIT_W'(1) :
        credit_dn[gi]                      ? credit_cnt_q[gi] - CREDIT_W'(1) :
                                             credit_cnt_q[gi];

    // Head while busy, or non-head while idle, is a framing violation.
    assign pkt_err[gi] = grant_oh[gi] &
                         (head_i[gi] ? in_pkt_q[gi] : ~in_pkt_q[gi]);

    assign in_pkt_d[gi] =
        (grant_oh[gi] &&  head_i[gi] && !tail_i[gi]) ? 1'b1 :
        (grant_oh[gi] && !head_i[gi] &&  tail_i[gi]) ? 1'b0 :
                                                       in_pkt_q[gi];
  end

  // Round-robin search from rr_ptr+1; V is a power of two so the wrap is free.
  always_comb begin
    grant_oh  = '0;
    grant_vc  = '0;
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 1; k <= V; k++) begin
      arb_idx = rr_ptr_q + V_BW'(k);
      if (!arb_found && elig[arb_idx]) begin
        arb_found         = 1'b1;
        grant_oh[arb_idx] = 1'b1;
        grant_vc          = arb_idx;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (arb_found) begin
      rr_ptr_d = grant_vc;
    end
    err_d = err_q | (|credit_ovf) | (|pkt_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < V; i++) begin
        credit_cnt_q[i] <= CREDIT_MAX;
      end
      rr_ptr_q <= PTR_RESET;
      in_pkt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      for (int i = 0; i < V; i++) begin
        credit_cnt_q[i] <= credit_cnt_d[i];
      end
      rr_ptr_q <= rr_ptr_d;
      in_pkt_q <= in_pkt_d;
      err_q    <= err_d;
    end
  end

  assign grant_valid_o  = arb_found;
  assign grant_o        = grant_oh;
  assign grant_vc_o     = grant_vc;
  assign vc_busy_o      = in_pkt_q;
  assign credit_avail_o = credit_nz;
  assign err_o          = err_q;

endmodule

// File: tb/tb_output_vc_credit_scheduler.sv
// Directed test-plan scenarios plus randomized traffic, all checked against
// a cycle-level behavioural model of credits, round-robin order and framing.
module tb_output_vc_credit_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_i, head_i, tail_i;
  logic       credit_valid_i;
  logic [1:0] credit_vc_i;
  logic       grant_valid_o;
  logic [3:0] grant_o;
  logic [1:0] grant_vc_o;
  logic [3:0] vc_busy_o, credit_avail_o;
  logic       err_o;

  always #5 clk = ~clk;

  output_vc_credit_scheduler dut (
    .clk            (clk),
    .reset          (reset),
    .req_i          (req_i),
    .head_i         (head_i),
    .tail_i         (tail_i),
    .credit_valid_i (credit_valid_i),
    .credit_vc_i    (credit_vc_i),
    .grant_valid_o  (grant_valid_o),
    .grant_o        (grant_o),
    .grant_vc_o     (grant_vc_o),
    .vc_busy_o      (vc_busy_o),
    .credit_avail_o (credit_avail_o),
    .err_o          (err_o)
  );

  int m_cnt [4];
  int m_ptr;
  bit m_busy [4];
  bit m_err;
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_cnt[i]  = 4;
      m_busy[i] = 1'b0;
    end
    m_ptr = 3;
    m_err = 1'b0;
  endtask

  // exp_g: VC the test plan demands, -1 = no grant, -2 = no plan constraint.
  task automatic step(input bit rst, input logic [3:0] req, input logic [3:0] hd,
                      input logic [3:0] tl, input bit cv, input logic [1:0] cvid,
                      input int exp_g);
    int g;
    int idx;
    logic [3:0] exp_busy, exp_avail;
    @(negedge clk);
    reset = rst; req_i = req; head_i = hd; tail_i = tl;
    credit_valid_i = cv; credit_vc_i = cvid;
    #1;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_ptr + k) % 4;
      if (g < 0 && req[idx] && m_cnt[idx] > 0) g = idx;
    end
    for (int i = 0; i < 4; i++) begin
      exp_busy[i]  = m_busy[i];
      exp_avail[i] = (m_cnt[i] > 0);
    end
    check_val("grant_valid", 32'(grant_valid_o), 32'(g >= 0));
    check_val("grant_onehot", 32'(grant_o), (g >= 0) ? (32'd1 << g) : 32'd0);
    check_val("grant_vc", 32'(grant_vc_o), (g >= 0) ? 32'(g) : 32'd0);
    check_val("vc_busy", 32'(vc_busy_o), 32'(exp_busy));
    check_val("credit_avail", 32'(credit_avail_o), 32'(exp_avail));
    check_val("err", 32'(err_o), 32'(m_err));
    if (exp_g != -2)
      check_val("plan_grant", grant_valid_o ? 32'(grant_vc_o) : 32'hFFFF_FFFF, 32'(exp_g));
    $display("cyc t=%0t rst=%0b req=%b hd=%b tl=%b cr=%0b/%0d -> gv=%0b gvc=%0d busy=%b avail=%b err=%0b",
             $time, rst, req, hd, tl, cv, cvid, grant_valid_o, grant_vc_o,
             vc_busy_o, credit_avail_o, err_o);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0) m_ptr = g;
      for (int i = 0; i < 4; i++) begin
        bit inc, dec;
        inc = cv && (int'(cvid) == i);
        dec = (g == i);
        if (inc && !dec) begin
          if (m_cnt[i] == 4) m_err = 1'b1;
          else m_cnt[i]++;
        end else if (dec && !inc) begin
          m_cnt[i]--;
        end
      end
      if (g >= 0) begin
        if (hd[g] && m_busy[g]) m_err = 1'b1;
        if (!hd[g] && !m_busy[g]) m_err = 1'b1;
        if (hd[g] && !tl[g]) m_busy[g] = 1'b1;
        if (!hd[g] && tl[g]) m_busy[g] = 1'b0;
      end
    end
  endtask

  initial begin
    int seq [6];
    reset = 1'b1; req_i = '0; head_i = '0; tail_i = '0;
    credit_valid_i = 1'b0; credit_vc_i = '0;
    repeat (2) @(posedge clk);
    model_reset();

    // Reset state
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);

    // Fairness with single-flit packets and immediate credit return
    seq = '{0, 1, 2, 3, 0, 1};
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    for (int i = 0; i < 6; i++)
      step(0, 4'hF, 4'hF, 4'hF, 1, 2'(seq[i]), seq[i]);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);

    // Credit exhaustion on VC2, then a single return
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    for (int i = 0; i < 4; i++)
      step(0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd0, 2);
    step(0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd0, -1);
    step(0, 4'b0100, 4'b0100, 4'b0100, 1, 2'd2, -1);
    step(0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd0, 2);
    step(0, 4'b0100, 4'b0100, 4'b0100, 0, 2'd0, -1);

    // Simultaneous grant and return on VC1
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    step(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0, 1);
    step(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0, 1);
    step(0, 4'b0010, 4'b0010, 4'b0010, 1, 2'd1, 1);
    step(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0, 1);
    step(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0, 1);
    step(0, 4'b0010, 4'b0010, 4'b0010, 0, 2'd0, -1);

    // Credit overflow is sticky until reset
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    step(0, 4'h0, 4'h0, 4'h0, 1, 2'd3, -1);
    for (int i = 0; i < 3; i++)
      step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);

    // Packet tracking on VC1: head, body, tail, head, duplicate head
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    step(0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd0, 1);
    step(0, 4'b0010, 4'b0000, 4'b0000, 1, 2'd1, 1);
    step(0, 4'b0010, 4'b0000, 4'b0010, 1, 2'd1, 1);
    step(0, 4'b0010, 4'b0010, 4'b0000, 1, 2'd1, 1);
    step(0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd0, 1);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);

    // Reset mid-packet with partial credits
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    step(0, 4'b0001, 4'b0001, 4'b0000, 0, 2'd0, 0);
    step(0, 4'b0010, 4'b0010, 4'b0000, 0, 2'd0, 1);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);
    step(0, 4'hF, 4'hF, 4'hF, 0, 2'd0, 0);
    // Body flit after reset is a framing error
    step(1, 4'h0, 4'h0, 4'h0, 0, 2'd0, -2);
    step(0, 4'b0001, 4'b0000, 4'b0000, 0, 2'd0, 0);
    step(0, 4'h0, 4'h0, 4'h0, 0, 2'd0, -1);

    // Randomized traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 99) < 3), 4'($urandom), 4'($urandom), 4'($urandom),
           ($urandom_range(0, 9) < 4), 2'($urandom), -2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/output_vc_credit_scheduler.md
Name: output_vc_credit_scheduler

Overview:
- Per-output-port flit scheduler for the VC-based mesh router.
- Each cycle it selects one input VC to drive the crossbar output, using round-robin among eligible requesters.
- Tracks downstream buffer credits per VC and per-VC packet state (head to tail).
- Returned-credit VC ids arrive binary-encoded and are decoded internally to one-hot. The grant is presented in both one-hot and binary form.

Parameters:
- V, 4, number of virtual channels; input VC i maps to downstream VC i.
- V_BW, 2, binary VC id width (log2 V).
- CREDIT_NUM, 4, downstream buffer depth per VC; also the reset credit value.
- CREDIT_W, 3, credit counter width; must hold 0..CREDIT_NUM.

Ports:
- clk, input, 1, single clock; all state updates on its rising edge.
- reset, input, 1, synchronous active-high reset.
- req_i, input, V, bit i = VC i holds a flit for this output.
- head_i, input, V, bit i = VC i's front flit is a head flit.
- tail_i, input, V, bit i = VC i's front flit is a tail flit; a single-flit packet has head and tail both set.
- credit_valid_i, input, 1, one credit returned this cycle.
- credit_vc_i, input, V_BW, binary id of the VC whose credit is returned.
- grant_valid_o, output, 1, a flit is transferred this cycle.
- grant_o, output, V, one-hot grant; all zero when grant_valid_o=0.
- grant_vc_o, output, V_BW, binary id of the granted VC; 0 when no grant.
- vc_busy_o, output, V, bit i = a packet is in progress on VC i.
- credit_avail_o, output, V, bit i = credit counter i is nonzero.
- err_o, output, 1, sticky protocol-error flag.

Behaviour:
- Reset (synchronous, dominates all other inputs):
  - credit_cnt[i]=CREDIT_NUM for all i.
  - rr_ptr=V-1, so VC0 has first priority.
  - in_pkt=0, err=0.
  - Resulting outputs: grant_valid_o=0 only if req_i=0; vc_busy_o=0; credit_avail_o=all ones; err_o=0.
- Eligibility (combinational): elig[i] = req_i[i] & (credit_cnt[i]!=0).
- Arbitration (combinational, zero latency from req_i to grant):
  - Search elig starting at index rr_ptr+1 and wrap modulo V.
  - The first set bit wins.
  - grant_valid_o = |elig.
  - grant_o is exactly one-hot or zero; grant_vc_o is its binary encoding.
- Register updates on each clock edge when not in reset:
  - Round-robin pointer: if grant_valid_o, rr_ptr <= grant_vc_o; otherwise hold.
  - Credits: the grant decrements credit_cnt[g]. A credit return increments credit_cnt[credit_vc_i]; the binary id is decoded to one-hot first.
  - Grant and credit return on the same VC in the same cycle: counter unchanged.
  - Credit return to a VC already at CREDIT_NUM: counter saturates (unchanged) and err <= 1.
  - Counter never decrements below 0; this is guaranteed by eligibility.
  - Packet state on a granted VC g:
    - head&!tail: in_pkt[g] <= 1.
    - !head&tail: in_pkt[g] <= 0.
    - head&tail: in_pkt[g] unchanged.
    - !head&!tail (body): unchanged.
- Protocol errors (sticky, set err <= 1; cleared only by reset):
  - Granted head flit while in_pkt[g]=1.
  - Granted non-head flit while in_pkt[g]=0.
  - The packet-state update is still applied on an error grant.
- Output decoding:
  - vc_busy_o = in_pkt.
  - credit_avail_o[i] = (credit_cnt[i]!=0).
  - err_o = err.
- Throughput: one flit per cycle maximum, with no bubble between consecutive grants.
- A credit returned in cycle n makes its VC eligible in cycle n+1; there is no same-cycle bypass.
- Reset mid-packet: all in-flight state is discarded; a body flit offered after reset raises err_o.

Test Plan:
- Fairness: after reset, req_i=4'b1111, all head&tail flits, credits returned each cycle for the granted VC → grant_vc_o sequence 0,1,2,3,0,1; err_o=0.
- Credit exhaustion: req_i=4'b0100 only, no credit returns → 4 grants of VC2, then grant_valid_o=0 and credit_avail_o[2]=0. Pulse credit_valid_i with credit_vc_i=2 in cycle n → grant of VC2 in cycle n+1.
- Simultaneous: VC1 at count 2, granted in the same cycle credit_vc_i=1 is returned → count stays 2. Verify by then granting 2 more times with no returns, after which VC1 is stalled.
- Overflow: credit_valid_i=1, credit_vc_i=3 right after reset → err_o=1 next cycle; credit_cnt[3] stays 4; err_o stays 1 until reset.
- Packet tracking: VC1 head (tail=0) granted → vc_busy_o[1]=1; body keeps it at 1; tail → vc_busy_o[1]=0, err_o=0. A second head on VC1 while busy → err_o=1.
- Reset mid-operation: with vc_busy_o=4'b0011 and partial credits, assert reset for 1 cycle → vc_busy_o=0, credit_avail_o=4'b1111, next grant with req_i=4'b1111 is VC0.
